md5_crack_dispatch: RTL and testbench

- Front-end controller for the password cracker; sits directly upstream of N_CORES md5_bf brute-force cores.
- Splits the 8-digit decimal password space (BCD-encoded, 32'h00000000..32'h99999999) into fixed chunks and hands each chunk to an idle core.
- Recycles each core by pulsing its reset and start.
- Collects the first hit and reports a single found/pass/done result to the UART/LCD top level.

---
 rtl/md5_crack_pkg.sv | 19 +
 rtl/md5_crack_dispatch_bcd_counter.sv | 43 ++++
 rtl/md5_crack_dispatch.sv | 200 ++++++++++++++++++++
 tb/tb_md5_crack_dispatch.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_crack_pkg.sv
// Shared types and constants for the md5 brute-force dispatch front end.
package md5_crack_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} top_state_t;
    typedef enum logic [1:0] {C_IDLE, C_RST, C_START, C_RUN} core_state_t;

    localparam logic [31:0] BCD_MAX_PASS = 32'h99999999;

    // Number of chunks the 8-digit space splits into for a given chunk width.
    function automatic int unsigned chunk_count(input int unsigned chunk_digits);
        int unsigned n;
        n = 1;
        for (int unsigned i = chunk_digits; i < 8; i++) begin
            n = n * 10;
        end
        return n;
    endfunction

endpackage

// File: rtl/md5_crack_dispatch_bcd_counter.sv
// Multi-digit BCD counter with decimal carry; holds at all-9s instead of wrapping.
module bcd_counter #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                clr,
    output logic [4*DIGITS-1:0] value,
    output logic                last
);

    logic [4*DIGITS-1:0] next_value;

    always_comb begin
        logic carry;
        next_value = value;
        carry      = 1'b1;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (value[4*d +: 4] == 4'd9) begin
                    next_value[4*d +: 4] = 4'd0;
                end else begin
                    next_value[4*d +: 4] = value[4*d +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
    end

    assign last = (value == {DIGITS{4'h9}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en && !last) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/md5_crack_dispatch.sv
// Splits the BCD password space into chunks, feeds idle md5_bf cores and
// reports the first hit (lowest core index on ties).
module md5_crack_dispatch
    import md5_crack_pkg::*;
#(
    parameter int unsigned N_CORES      = 4,
    parameter int unsigned CHUNK_DIGITS = 6,
    parameter int unsigned RST_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  go,
    input  logic [127:0]          hash_in,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [31:0]           pass,
    output logic [7:0]            chunks_done,
    output logic [N_CORES-1:0]    core_rst_n,
    output logic [N_CORES-1:0]    core_start,
    output logic [32*N_CORES-1:0] core_low,
    output logic [32*N_CORES-1:0] core_high,
    output logic [127:0]          core_hash,
    input  logic [N_CORES-1:0]    core_done,
    input  logic [N_CORES-1:0]    core_found,
    input  logic [32*N_CORES-1:0] core_pass
);

    localparam int unsigned IDX_DIGITS = 8 - CHUNK_DIGITS;
    localparam int unsigned IDX_W      = 4 * IDX_DIGITS;
    localparam int unsigned CNT_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    top_state_t state;
    logic [IDX_W-1:0] idx;
    logic idx_last;
    logic all_dispatched;

    logic [N_CORES-1:0] idle_vec, run_vec, hit_vec, miss_vec, disp_vec;
    logic hit_any, disp_any, go_ok, abort;
    logic [31:0] hit_pass, chunk_low, chunk_high;
    logic [3:0] miss_cnt;
    logic [8:0] chunks_sum;
    logic [7:0] chunks_next;

    assign go_ok      = go && (state != S_RUN);
    assign chunk_low  = {idx, {(4*CHUNK_DIGITS){1'b0}}};
    assign chunk_high = chunk_low | (BCD_MAX_PASS >> IDX_W);

    bcd_counter #(.DIGITS(IDX_DIGITS)) u_chunk_idx (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (disp_any),
        .clr     (go_ok),
        .value   (idx),
        .last    (idx_last)
    );

    always_comb begin
        logic hit_taken, disp_taken;
        hit_vec    = '0;
        miss_vec   = '0;
        disp_vec   = '0;
        hit_pass   = '0;
        miss_cnt   = '0;
        hit_taken  = 1'b0;
        disp_taken = 1'b0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            hit_vec[i]  = run_vec[i] && core_done[i] && core_found[i];
            miss_vec[i] = run_vec[i] && core_done[i] && !core_found[i];
            miss_cnt    = miss_cnt + 4'(miss_vec[i]);
            if (hit_vec[i] && !hit_taken) begin
                hit_pass  = core_pass[32*i +: 32];
                hit_taken = 1'b1;
            end
        end
        hit_any = hit_taken;
        // A hit in the same cycle suppresses the dispatch since all cores get parked.
        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (state == S_RUN && !all_dispatched && !hit_taken && idle_vec[i] && !disp_taken) begin
                disp_vec[i] = 1'b1;
                disp_taken  = 1'b1;
            end
        end
        disp_any    = disp_taken;
        chunks_sum  = {1'b0, chunks_done} + 9'(miss_cnt);
        chunks_next = chunks_sum[8] ? 8'hFF : chunks_sum[7:0];
    end

    assign abort = (state != S_RUN) || hit_any;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            found          <= 1'b0;
            pass           <= '0;
            chunks_done    <= '0;
            core_hash      <= '0;
            all_dispatched <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        state          <= S_RUN;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        found          <= 1'b0;
                        pass           <= '0;
                        chunks_done    <= '0;
                        core_hash      <= hash_in;
                        all_dispatched <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (hit_any) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        found <= 1'b1;
                        pass  <= hit_pass;
                    end else begin
                        chunks_done <= chunks_next;
                        if (disp_any && idx_last) begin
                            all_dispatched <= 1'b1;
                        end
                        if (all_dispatched && (&idle_vec)) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < N_CORES; g++) begin : g_core
        core_state_t cs;
        logic [CNT_W-1:0] rcnt;
        logic rst_q, start_q;
        logic [31:0] low_q, high_q;

        assign idle_vec[g]           = (cs == C_IDLE);
        assign run_vec[g]            = (cs == C_RUN);
        assign core_rst_n[g]         = rst_q;
        assign core_start[g]         = start_q;
        assign core_low[32*g +: 32]  = low_q;
        assign core_high[32*g +: 32] = high_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cs      <= C_IDLE;
                rcnt    <= '0;
                rst_q   <= 1'b0;
                start_q <= 1'b0;
                low_q   <= '0;
                high_q  <= '0;
            end else if (abort) begin
                cs      <= C_IDLE;
                rst_q   <= 1'b0;
                start_q <= 1'b0;
            end else begin
                case (cs)
                    C_IDLE: begin
                        if (disp_vec[g]) begin
                            cs     <= C_RST;
                            rcnt   <= CNT_W'(RST_CYCLES - 1);
                            rst_q  <= 1'b0;
                            low_q  <= chunk_low;
                            high_q <= chunk_high;
                        end
                    end
                    C_RST: begin
                        if (rcnt == '0) begin
                            cs      <= C_START;
                            rst_q   <= 1'b1;
                            start_q <= 1'b1;
                        end else begin
                            rcnt <= rcnt - 1'b1;
                        end
                    end
                    C_START: begin
                        cs      <= C_RUN;
                        start_q <= 1'b0;
                    end
                    C_RUN: begin
                        if (core_done[g]) begin
                            cs    <= C_IDLE;
                            rst_q <= 1'b0;
                        end
                    end
                    default: cs <= C_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_md5_crack_dispatch.sv
// Bench for md5_crack_dispatch using randomized-latency stub cores and a chunk-order model.
module tb_md5_crack_dispatch;
    import md5_crack_pkg::*;

    localparam int unsigned N  = 2;
    localparam int unsigned CD = 6;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           go = 1'b0;
    logic [127:0]   hash_in = '0;
    logic           busy, done, found;
    logic [31:0]    pass;
    logic [7:0]     chunks_done;
    logic [N-1:0]   core_rst_n, core_start;
    logic [32*N-1:0] core_low, core_high;
    logic [127:0]   core_hash;
    logic [N-1:0]   core_done = '0;
    logic [N-1:0]   core_found = '0;
    logic [32*N-1:0] core_pass = '0;

    always #5 clk = ~clk;

    md5_crack_dispatch #(.N_CORES(N), .CHUNK_DIGITS(CD), .RST_CYCLES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .go          (go),
        .hash_in     (hash_in),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .pass        (pass),
        .chunks_done (chunks_done),
        .core_rst_n  (core_rst_n),
        .core_start  (core_start),
        .core_low    (core_low),
        .core_high   (core_high),
        .core_hash   (core_hash),
        .core_done   (core_done),
        .core_found  (core_found),
        .core_pass   (core_pass)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_low(input int k);
        return (32'(k / 10) << 28) | (32'(k % 10) << 24);
    endfunction

    function automatic logic [31:0] rand_digits(input int n);
        logic [31:0] v;
        v = '0;
        for (int d = 0; d < n; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Stub cores: finish after a random latency, report a hit if the programmed password is in range.
    int          cyc = 0;
    logic [N-1:0] st_active = '0;
    int          st_cnt [N];
    int          st_lat [N];
    logic [31:0] st_low [N];
    logic [31:0] st_high [N];
    bit          hit_en = 0;
    logic [31:0] hit_pass = '0;
    bit          force_en = 0;
    int          force_at = -1;
    logic [31:0] force_pass [N];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) begin
            core_done[i]  <= 1'b0;
            core_found[i] <= 1'b0;
            if (!core_rst_n[i]) begin
                st_active[i] <= 1'b0;
            end else if (core_start[i]) begin
                st_active[i] <= 1'b1;
                st_cnt[i]    <= 0;
                st_lat[i]    <= $urandom_range(10, 30);
                st_low[i]    <= core_low[32*i +: 32];
                st_high[i]   <= core_high[32*i +: 32];
            end else if (st_active[i]) begin
                if (force_en) begin
                    if (cyc == force_at) begin
                        core_done[i]          <= 1'b1;
                        core_found[i]         <= 1'b1;
                        core_pass[32*i +: 32] <= force_pass[i];
                        st_active[i]          <= 1'b0;
                    end
                end else if (st_cnt[i] + 1 >= st_lat[i]) begin
                    core_done[i]          <= 1'b1;
                    core_found[i]         <= hit_en && hit_pass >= st_low[i] && hit_pass <= st_high[i];
                    core_pass[32*i +: 32] <= hit_pass;
                    st_active[i]          <= 1'b0;
                end else begin
                    st_cnt[i] <= st_cnt[i] + 1;
                end
            end
        end
    end

    // Every core start must carry the next chunk in decimal order.
    int next_chunk = 0;
    bit mon_en = 0;
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            for (int i = 0; i < N; i++) begin
                if (core_start[i]) begin
                    check("start_low", core_low[32*i +: 32], exp_low(next_chunk));
                    check("start_high", core_high[32*i +: 32],
                          exp_low(next_chunk) | (BCD_MAX_PASS & 32'h00FFFFFF));
                    next_chunk++;
                end
            end
        end
    end

    task automatic do_go(input logic [127:0] h);
        @(negedge clk);
        hash_in = h;
        go = 1'b1;
        next_chunk = 0;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_hit(output bit ok);
        ok = 0;
        for (int c = 0; c < 5000; c++) begin
            if (|(core_done & core_found)) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int c = 0; c < 5000; c++) begin
            if (done) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_hit_result(input string tag, input logic [31:0] exp_pass);
        bit ok;
        wait_hit(ok);
        check({tag, "_hit_seen"}, 128'(ok), 128'(1));
        @(negedge clk);
        check({tag, "_done"}, 128'(done), 128'(1));
        check({tag, "_found"}, 128'(found), 128'(1));
        check({tag, "_pass"}, 128'(pass), 128'(exp_pass));
        check({tag, "_rst_parked"}, 128'(core_rst_n), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        logic [127:0] h1, h2, h3, h4, h5;
        logic [31:0]  pa, pb, rp;
        bit ok;

        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_found", 128'(found), 128'(0));
        check("rst_pass", 128'(pass), 128'(0));
        check("rst_chunks", 128'(chunks_done), 128'(0));
        check("rst_core_rst_n", 128'(core_rst_n), 128'(0));
        check("rst_core_start", 128'(core_start), 128'(0));
        check("rst_core_low", 128'(core_low), 128'(0));
        check("rst_core_high", 128'(core_high), 128'(0));
        check("rst_core_hash", core_hash, 128'(0));
        reset_n = 1'b1;
        mon_en = 1;

        // Full sweep without any hit.
        h1 = {$urandom, $urandom, $urandom, $urandom};
        do_go(h1);
        check("run_busy", 128'(busy), 128'(1));
        check("run_hash", core_hash, h1);
        wait_done(ok);
        check("sweep_done_seen", 128'(ok), 128'(1));
        check("sweep_found", 128'(found), 128'(0));
        check("sweep_chunks", 128'(chunks_done), 128'(chunk_count(CD)));
        check("sweep_dispatched", 128'(next_chunk), 128'(chunk_count(CD)));
        check("sweep_rst_parked", 128'(core_rst_n), 128'(0));

        // Directed hit inside chunk 53.
        hit_en = 1;
        hit_pass = 32'h53480517;
        do_go({$urandom, $urandom, $urandom, $urandom});
        check_hit_result("hit53", 32'h53480517);

        // Random hit in an early chunk.
        rp = exp_low($urandom_range(0, 15)) | rand_digits(6);
        hit_pass = rp;
        do_go({$urandom, $urandom, $urandom, $urandom});
        check_hit_result("hit_rand", rp);

        // Both cores report found in the same cycle: core 0 wins.
        pa = rand_digits(8);
        pb = rand_digits(8) ^ 32'h00000001;
        force_pass[0] = pa;
        force_pass[1] = pb;
        force_en = 1;
        do_go({$urandom, $urandom, $urandom, $urandom});
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            if (st_active == 2'b11) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("tie_both_active", 128'(ok), 128'(1));
        force_at = cyc + 2;
        check_hit_result("tie", pa);
        force_en = 0;

        // Asynchronous reset in the middle of a search.
        hit_en = 0;
        do_go({$urandom, $urandom, $urandom, $urandom});
        repeat (150) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_chunks", 128'(chunks_done), 128'(0));
        check("arst_core_rst_n", 128'(core_rst_n), 128'(0));
        check("arst_core_low", 128'(core_low), 128'(0));
        check("arst_core_high", 128'(core_high), 128'(0));
        check("arst_core_hash", core_hash, 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        hit_en = 1;
        rp = exp_low(2) | rand_digits(6);
        hit_pass = rp;
        h2 = {$urandom, $urandom, $urandom, $urandom};
        do_go(h2);
        check("arst_new_hash", core_hash, h2);
        check_hit_result("arst_restart", rp);

        // go in RUN is ignored; go in DONE restarts with a new hash.
        rp = exp_low(5) | rand_digits(6);
        hit_pass = rp;
        h3 = {$urandom, $urandom, $urandom, $urandom};
        h4 = ~h3;
        do_go(h3);
        repeat (30) @(negedge clk);
        hash_in = h4;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("rungo_hash_kept", core_hash, h3);
        check("rungo_busy", 128'(busy), 128'(1));
        check_hit_result("rungo", rp);
        hit_en = 0;
        h5 = {$urandom, $urandom, $urandom, $urandom};
        do_go(h5);
        check("regō_found_clr", 128'(found), 128'(0));
        check("rego_chunks_clr", 128'(chunks_done), 128'(0));
        check("rego_hash", core_hash, h5);
        check("rego_busy", 128'(busy), 128'(1));
        check("rego_done_clr", 128'(done), 128'(0));
        repeat (10) @(negedge clk);
        check("rego_dispatch_started", 128'(next_chunk >= 1), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
